// File: rtl/jtpang_pkg.sv
// Shared constants and helpers for the Pang colour mixer: palette geometry,
// obj transparency default, pipeline depth and palette byte-lane encoding.
package jtpang_pkg;

    localparam int         PAL_AW         = 11;
    localparam int         PAL_DW         = 8;
    localparam logic [3:0] OBJ_TRANSP_DEF = 4'hF;
    localparam int         LAT_DEF        = 3;

    typedef enum logic {
        LANE_GB = 1'b0,
        LANE_R  = 1'b1
    } lane_e;

    function automatic logic obj_opaque(input logic [3:0] col,
                                        input logic [3:0] transp,
                                        input logic       en);
        return en && (col != transp);
    endfunction

endpackage

// File: rtl/jtpang_colmix_if.sv
// CPU-side palette bus of the colour mixer: select, write strobe, byte address,
// write data and read-back data.
interface jtpang_colmix_if;
    import jtpang_pkg::*;

    logic              pal_cs;
    logic              wr_n;
    logic [PAL_AW:0]   cpu_addr;
    logic [PAL_DW-1:0] cpu_dout;
    logic [PAL_DW-1:0] pal_dout;

    modport master (output pal_cs, wr_n, cpu_addr, cpu_dout, input pal_dout);
    modport slave  (input pal_cs, wr_n, cpu_addr, cpu_dout, output pal_dout);
endinterface

// File: rtl/jtframe_dual_ram.sv
// True dual-port RAM with per-port clock enable. Reads are read-first, so a
// port reading an entry written on the same edge gets the previous contents.
module jtframe_dual_ram #(
    parameter int aw = 11,
    parameter int dw = 8
) (
    input  logic          clk,
    input  logic          cen0,
    input  logic [dw-1:0] data0,
    input  logic [aw-1:0] addr0,
    input  logic          we0,
    output logic [dw-1:0] q0,
    input  logic          cen1,
    input  logic [dw-1:0] data1,
    input  logic [aw-1:0] addr1,
    input  logic          we1,
    output logic [dw-1:0] q1
);

    logic [dw-1:0] mem_q [0:(2**aw)-1];

    // Both ports share one process so the array has a single driver.
    always_ff @(posedge clk) begin
        if (cen0) begin
            q0 <= mem_q[addr0];
            if (we0) mem_q[addr0] <= data0;
        end
        if (cen1) begin
            q1 <= mem_q[addr1];
            if (we1) mem_q[addr1] <= data1;
        end
    end

endmodule

// File: rtl/jtpang_colmix.sv
// Pang colour mixer: obj/char priority, 2048-entry 12-bit palette shared with
// the CPU, and a three-stage pixel pipeline with aligned blanking.
module jtpang_colmix
    import jtpang_pkg::*;
#(
    parameter logic [3:0] OBJ_TRANSP = OBJ_TRANSP_DEF,
    parameter int         LAT        = LAT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pxl_cen,
    input  logic            LHBL,
    input  logic            LVBL,
    input  logic [10:0]     char_pxl,
    input  logic [7:0]      obj_pxl,
    input  logic [1:0]      gfx_en,
    jtpang_colmix_if.slave  cpu,
    output logic [3:0]      red,
    output logic [3:0]      green,
    output logic [3:0]      blue,
    output logic            LHBL_dly,
    output logic            LVBL_dly
);

    logic [PAL_AW-1:0] idx_d, idx_q;
    logic [LAT-1:0]    hb_q, vb_q;
    logic [11:0]       rgb_d, rgb_q;
    logic              we_s, we_gb_s, we_r_s, lane_q;
    logic [7:0]        cpu_gb_s, cpu_r_s, pxl_gb_s, pxl_r_s;
    logic              unused_s;

    assign we_s    = cpu.pal_cs & ~cpu.wr_n;
    assign we_gb_s = we_s & (lane_e'(cpu.cpu_addr[0]) == LANE_GB);
    assign we_r_s  = we_s & (lane_e'(cpu.cpu_addr[0]) == LANE_R);

    jtframe_dual_ram #(.aw(PAL_AW), .dw(PAL_DW)) u_ram_gb (
        .clk   (clk),
        .cen0  (1'b1),
        .data0 (cpu.cpu_dout),
        .addr0 (cpu.cpu_addr[PAL_AW:1]),
        .we0   (we_gb_s),
        .q0    (cpu_gb_s),
        .cen1  (pxl_cen),
        .data1 (8'h00),
        .addr1 (idx_q),
        .we1   (1'b0),
        .q1    (pxl_gb_s)
    );

    jtframe_dual_ram #(.aw(PAL_AW), .dw(PAL_DW)) u_ram_r (
        .clk   (clk),
        .cen0  (1'b1),
        .data0 (cpu.cpu_dout),
        .addr0 (cpu.cpu_addr[PAL_AW:1]),
        .we0   (we_r_s),
        .q0    (cpu_r_s),
        .cen1  (pxl_cen),
        .data1 (8'h00),
        .addr1 (idx_q),
        .we1   (1'b0),
        .q1    (pxl_r_s)
    );

    // Lane of the previous address picks which RAM answers the CPU read.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= 1'b0;
        end else begin
            lane_q <= cpu.cpu_addr[0];
        end
    end

    assign cpu.pal_dout = lane_q ? cpu_r_s : cpu_gb_s;
    assign unused_s     = ^pxl_r_s[7:4];

    // Layer priority: opaque obj over char over the backdrop entry 0x7FF.
    always_comb begin
        idx_d = 11'h7FF;
        if (obj_opaque(obj_pxl[3:0], OBJ_TRANSP, gfx_en[1])) begin
            idx_d = {3'b000, obj_pxl};
        end else if (gfx_en[0]) begin
            idx_d = char_pxl;
        end else begin
            idx_d = 11'h7FF;
        end
    end

    // Stage 3 blanks with the blank bits that travelled alongside this pixel.
    always_comb begin
        rgb_d = 12'h000;
        if (hb_q[LAT-2] && vb_q[LAT-2]) begin
            rgb_d = {pxl_r_s[3:0], pxl_gb_s};
        end else begin
            rgb_d = 12'h000;
        end
    end

    // Pixel pipeline registers, all advancing only on pxl_cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 11'h000;
            hb_q  <= '0;
            vb_q  <= '0;
            rgb_q <= 12'h000;
        end else if (pxl_cen) begin
            idx_q <= idx_d;
            hb_q  <= {hb_q[LAT-2:0], LHBL};
            vb_q  <= {vb_q[LAT-2:0], LVBL};
            rgb_q <= rgb_d;
        end
    end

    assign red      = rgb_q[11:8];
    assign green    = rgb_q[7:4];
    assign blue     = rgb_q[3:0];
    assign LHBL_dly = hb_q[LAT-1];
    assign LVBL_dly = vb_q[LAT-1];

endmodule

// File: tb/tb_jtpang_colmix.sv
// Scoreboard bench for jtpang_colmix: stimulus pushes hand-computed expected
// pixels and CPU reads; monitors pop and compare when each result is due.
module tb_jtpang_colmix;

    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_cen;
    logic        LHBL, LVBL;
    logic [10:0] char_pxl;
    logic [7:0]  obj_pxl;
    logic [1:0]  gfx_en;
    logic [3:0]  red, green, blue;
    logic        LHBL_dly, LVBL_dly;
    logic [1:0]  div;

    jtpang_colmix_if bus ();

    jtpang_colmix u_dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .char_pxl (char_pxl),
        .obj_pxl  (obj_pxl),
        .gfx_en   (gfx_en),
        .cpu      (bus),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL_dly (LHBL_dly),
        .LVBL_dly (LVBL_dly)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [13:0] v; } pix_exp_t;
    typedef struct { int due; logic [7:0] d; } cpu_exp_t;
    pix_exp_t pq[$];
    cpu_exp_t cq[$];

    int total = 0;
    int bad   = 0;
    int tick_n = 0;
    int cyc_n  = 0;
    logic        tick_seen = 1'b0, rst_seen = 1'b0, hold_ok = 1'b0;
    logic [13:0] held;

    // pxl_cen is high for one clk in every four
    initial begin
        pxl_cen = 1'b0;
        div     = 2'd0;
        forever begin
            @(negedge clk);
            pxl_cen = (div == 2'd3);
            div     = div + 2'd1;
        end
    end

    always @(posedge clk) begin
        cyc_n     <= cyc_n + 1;
        tick_seen <= pxl_cen;
        rst_seen  <= rst;
        if (pxl_cen) tick_n <= tick_n + 1;
    end

    function automatic logic [13:0] outs();
        return {red, green, blue, LHBL_dly, LVBL_dly};
    endfunction

    // Pixel monitor: due results, plus hold checks on edges without pxl_cen
    always @(negedge clk) begin
        if (pq.size() > 0 && pq[0].due < tick_n) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL pix_missed: due tick %0d, now tick %0d", pq[0].due, tick_n);
            void'(pq.pop_front());
        end else if (pq.size() > 0 && pq[0].due == tick_n) begin
            total = total + 1;
            if (outs() !== pq[0].v) begin
                bad = bad + 1;
                $display("FAIL pix@%0d: got rgbhv=%h expected %h", tick_n, outs(), pq[0].v);
            end
            void'(pq.pop_front());
        end
        if (hold_ok && !tick_seen && !rst_seen) begin
            total = total + 1;
            if (outs() !== held) begin
                bad = bad + 1;
                $display("FAIL hold: got %h expected %h", outs(), held);
            end
        end
        held    = outs();
        hold_ok = 1'b1;
    end

    // CPU read-back monitor
    always @(negedge clk) begin
        if (cq.size() > 0 && cq[0].due <= cyc_n) begin
            total = total + 1;
            if (cq[0].due != cyc_n || bus.pal_dout !== cq[0].d) begin
                bad = bad + 1;
                $display("FAIL pal_dout: got %h expected %h (due %0d now %0d)",
                         bus.pal_dout, cq[0].d, cq[0].due, cyc_n);
            end
            void'(cq.pop_front());
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!pxl_cen && n < 16);
        if (!pxl_cen) chk("tick_timeout", 14'h0001, 14'h0000);
    endtask

    task automatic pix(input logic [7:0] obj, input logic [10:0] chr, input logic [1:0] en,
                       input logic hb, input logic vb, input logic [11:0] exp_rgb);
        pix_exp_t e;
        wait_tick();
        obj_pxl  = obj;
        char_pxl = chr;
        gfx_en   = en;
        LHBL     = hb;
        LVBL     = vb;
        e.due = tick_n + 3;
        e.v   = {exp_rgb, hb, vb};
        pq.push_back(e);
    endtask

    task automatic cpu_wr(input logic [11:0] a, input logic [7:0] d);
        bus.cpu_addr = a;
        bus.cpu_dout = d;
        bus.pal_cs   = 1'b1;
        bus.wr_n     = 1'b0;
        @(negedge clk);
        #1;
        bus.pal_cs   = 1'b0;
        bus.wr_n     = 1'b1;
    endtask

    task automatic cpu_rd(input logic [11:0] a, input logic [7:0] d);
        cpu_exp_t e;
        bus.cpu_addr = a;
        bus.pal_cs   = 1'b1;
        bus.wr_n     = 1'b1;
        e.due = cyc_n + 1;
        e.d   = d;
        cq.push_back(e);
        @(negedge clk);
        #1;
        bus.pal_cs   = 1'b0;
    endtask

    initial begin
        pix_exp_t z;
        rst = 1'b1;
        LHBL = 1'b1; LVBL = 1'b1;
        obj_pxl = 8'h00; char_pxl = 11'h000; gfx_en = 2'b11;
        bus.pal_cs = 1'b0; bus.wr_n = 1'b1; bus.cpu_addr = 12'h000; bus.cpu_dout = 8'h00;
        repeat (6) @(negedge clk);
        chk("reset_outs", outs(), 14'h0000);
        #1;
        rst = 1'b0;

        // Palette: 0x010=R3 G5 BA, 0x123=R1 G2 B3, 0x7FF=R7 G8 B9
        cpu_wr(12'h020, 8'h5A);
        cpu_wr(12'h021, 8'h03);
        cpu_rd(12'h020, 8'h5A);
        cpu_rd(12'h021, 8'h03);
        cpu_wr(12'h0A1, 8'hA3);
        cpu_rd(12'h0A1, 8'hA3);
        cpu_wr(12'h246, 8'h23);
        cpu_wr(12'h247, 8'h01);
        cpu_wr(12'hFFE, 8'h89);
        cpu_wr(12'hFFF, 8'h07);

        // Priority and blanking
        pix(8'h10, 11'h123, 2'b11, 1'b1, 1'b1, 12'h35A);
        pix(8'h1F, 11'h123, 2'b11, 1'b1, 1'b1, 12'h123);
        pix(8'h10, 11'h123, 2'b01, 1'b1, 1'b1, 12'h123);
        pix(8'h1F, 11'h123, 2'b10, 1'b1, 1'b1, 12'h789);
        pix(8'h10, 11'h123, 2'b00, 1'b1, 1'b1, 12'h789);
        pix(8'h10, 11'h123, 2'b10, 1'b1, 1'b1, 12'h35A);
        pix(8'h10, 11'h123, 2'b11, 1'b0, 1'b1, 12'h000);
        pix(8'h10, 11'h123, 2'b11, 1'b1, 1'b1, 12'h35A);
        pix(8'h1F, 11'h123, 2'b11, 1'b1, 1'b0, 12'h000);
        pix(8'h1F, 11'h123, 2'b11, 1'b1, 1'b1, 12'h123);

        // Red rewrite of 0x010 lands on the same edge that reads the earlier pixel
        pix(8'h10, 11'h123, 2'b11, 1'b1, 1'b1, 12'h35A);
        pix(8'h10, 11'h123, 2'b11, 1'b1, 1'b1, 12'h35A);
        pix(8'h10, 11'h123, 2'b11, 1'b1, 1'b1, 12'hF5A);
        cpu_wr(12'h021, 8'h0F);
        pix(8'h10, 11'h123, 2'b11, 1'b1, 1'b1, 12'hF5A);
        pix(8'h1F, 11'h123, 2'b11, 1'b1, 1'b1, 12'h123);
        pix(8'h10, 11'h123, 2'b11, 1'b1, 1'b1, 12'hF5A);

        // One-clk reset on an edge without pxl_cen
        pix(8'h10, 11'h123, 2'b11, 1'b1, 1'b1, 12'hF5A);
        pix(8'h1F, 11'h123, 2'b11, 1'b1, 1'b1, 12'h123);
        @(negedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_now", outs(), 14'h0000);
        #1;
        rst = 1'b0;
        pq.delete();
        z.v = 14'h0000;
        z.due = tick_n + 1;
        pq.push_back(z);
        z.due = tick_n + 2;
        pq.push_back(z);
        pix(8'h10, 11'h123, 2'b11, 1'b1, 1'b1, 12'hF5A);
        pix(8'h1F, 11'h123, 2'b11, 1'b1, 1'b1, 12'h123);
        pix(8'h1F, 11'h000, 2'b00, 1'b1, 1'b1, 12'h789);
        cpu_rd(12'h021, 8'h0F);
        cpu_rd(12'h020, 8'h5A);

        repeat (5) wait_tick();
        chk("pix_queue_drained", 14'(pq.size()), 14'h0000);
        chk("cpu_queue_drained", 14'(cq.size()), 14'h0000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
